dlock_multi: RTL and testbench
==============================

Name: dlock_multi

Overview:
- Parametrised next-generation digital lock: DIGITS-digit password (BCD, one digit per keypress), a failed-attempt counter and a timed lockout.
- Sits between the keypad/button debounce logic and the actuator driver.
- Adds behaviour the 2-digit lock lacks: a full-length entry check, rising-edge command detection, a programmable lockout with ALARM, and a defined command priority.

Parameters:
- DIGITS, 4, password length in decimal digits (1..8); entry/password width = 4*DIGITS bits.
- MAX_FAIL, 3, consecutive failed OPEN attempts that trigger lockout (1..15).
- LOCKOUT_CYC, 1000, lockout duration in CLK cycles (>=1); timer width = $clog2(LOCKOUT_CYC+1).

Ports:
- CLK  input  1  system clock, all logic on rising edge.
- RESET  input  1  synchronous, active-low reset.
- KEY  input  10  keypad, bit i = digit i pressed (level, debounced).
- OPEN  input  1  open request (level; acted on at rising edge).
- CLOSE  input  1  close request (level; acted on while high).
- SET  input  1  set-password request (level; acted on at rising edge).
- LOCK  output  1  1 = unlocked/open.
- ALARM  output  1  1 while in lockout.
- DIGIT_CNT  output  4  digits currently held in the entry buffer (0..DIGITS).
- FAIL_CNT  output  4  consecutive failed attempts.

Behaviour:
- Reset (RESET=0 at a CLK edge): state CLOSED, LOCK=0, ALARM=0, DIGIT_CNT=0, FAIL_CNT=0, entry buffer=0, password=0 (all digits 0), timer=0, edge registers=0. Reset overrides everything, including mid-lockout and mid-entry.
- Edge detection: registered copies of KEY, OPEN, SET.
  - Key event = KEY has exactly one bit set AND previous KEY == 0.
  - Multi-key presses, or a change while a key is held, are ignored.
  - OPEN/SET event = high now AND low last cycle.
- Entry buffer: on a key event with DIGIT_CNT < DIGITS, buffer <= {buffer[4*DIGITS-5:0], digit} and DIGIT_CNT+1, both visible the cycle after the edge. Key events with DIGIT_CNT == DIGITS are discarded; no wrap.
- Priority per cycle: CLOSE > OPEN event > SET event > key event. A key event in the same cycle as a higher-priority action is discarded.
- State CLOSED (LOCK=0, ALARM=0):
  - OPEN event, DIGIT_CNT==DIGITS and buffer==password -> OPENED; LOCK=1 the cycle after the edge; FAIL_CNT=0; buffer and count cleared.
  - OPEN event, otherwise (mismatch or short entry) -> FAIL_CNT+1 (saturating at 15); buffer and count cleared.
    - If the new FAIL_CNT == MAX_FAIL -> LOCKOUT; timer <= LOCKOUT_CYC.
  - SET event: ignored.
  - CLOSE: clears buffer and count; FAIL_CNT unchanged.
- State OPENED (LOCK=1):
  - CLOSE -> CLOSED; LOCK=0 the next cycle; buffer and count cleared.
  - SET event with DIGIT_CNT==DIGITS -> password <= buffer; buffer and count cleared; stays OPENED.
  - SET event with short entry: ignored, buffer retained.
  - OPEN event: ignored (no fail count).
- State LOCKOUT (ALARM=1, LOCK=0):
  - Key, OPEN and SET events and CLOSE are all ignored; buffer held at 0.
  - Timer decrements each cycle; the cycle it reads 1 -> next state CLOSED, FAIL_CNT=0, ALARM=0.
  - ALARM is high for exactly LOCKOUT_CYC cycles.
- Password and entry comparison covers all 4*DIGITS bits. Digits are stored as BCD 0..9 only.

Test Plan:
- Reset, then keys 0,0,0,0 (DIGITS=4), OPEN pulse -> LOCK=1 the cycle after the OPEN edge; FAIL_CNT=0; DIGIT_CNT=0.
- While OPENED: keys 1,2,3,4, SET pulse; then CLOSE, keys 1,2,3,4, OPEN -> LOCK=1. Repeat with 1,2,3,5 -> LOCK stays 0, FAIL_CNT=1.
- Three wrong 4-digit entries, each followed by OPEN (MAX_FAIL=3, LOCKOUT_CYC=20) -> ALARM=1 for exactly 20 cycles; correct entry plus OPEN during lockout has no effect; afterwards FAIL_CNT=0 and a correct entry opens.
- Keys 1,2 then OPEN (short entry) -> FAIL_CNT=1, LOCK=0. Then 6 keys entered -> DIGIT_CNT saturates at 4 and the first 4 digits are kept. Key 3 and key 7 held together -> no digit stored. Key held for 5 cycles -> one digit stored.
- CLOSE and OPEN asserted in the same cycle while OPENED -> LOCK=0 (CLOSE wins). Key event in the same cycle as the OPEN edge -> key discarded.
- RESET=0 mid-lockout and mid-entry -> all outputs return to reset values the next cycle; password returns to 0000 (0000+OPEN opens).

Source files
------------

// File: rtl/dlock_multi.sv
// dlock_multi: multi-digit BCD keypad lock with failed-attempt counter and timed lockout.
module dlock_multi #(
  parameter int DIGITS      = 4,
  parameter int MAX_FAIL    = 3,
  parameter int LOCKOUT_CYC = 1000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [9:0] key_i,
  input  logic       open_i,
  input  logic       close_i,
  input  logic       set_i,
  output logic       lock_o,
  output logic       alarm_o,
  output logic [3:0] digit_cnt_o,
  output logic [3:0] fail_cnt_o
);
  localparam int W  = 4 * DIGITS;
  localparam int TW = $clog2(LOCKOUT_CYC + 1);
  typedef enum logic [1:0] {CLOSED, OPENED, LOCKOUT} state_t;
  state_t        state_q, state_d;
  logic [W-1:0]  buf_q, buf_d, pw_q, pw_d;
  logic [3:0]    cnt_q, cnt_d, fail_q, fail_d, fail_inc, digit;
  logic [TW-1:0] timer_q, timer_d;
  logic [9:0]    key_q;
  logic          open_q, set_q, key_ev, open_ev, set_ev, full;
  assign key_ev   = $onehot(key_i) && key_q == 10'd0;
  assign open_ev  = open_i && !open_q;
  assign set_ev   = set_i && !set_q;
  assign full     = cnt_q == 4'(DIGITS);
  assign fail_inc = fail_q == 4'hf ? fail_q : fail_q + 4'd1;
  always_comb begin
    digit = 4'd0;
    for (int i = 0; i < 10; i++) if (key_i[i]) digit = 4'(i);
  end
  // Lockout swallows every input; otherwise CLOSE > OPEN > SET > key.
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    pw_d    = pw_q;
    cnt_d   = cnt_q;
    fail_d  = fail_q;
    timer_d = timer_q;
    if (state_q == LOCKOUT) begin
      timer_d = timer_q - TW'(1);
      buf_d   = '0;
      cnt_d   = 4'd0;
      if (timer_q == TW'(1)) begin
        state_d = CLOSED;
        fail_d  = 4'd0;
      end
    end else if (close_i) begin
      state_d = CLOSED;
      buf_d   = '0;
      cnt_d   = 4'd0;
    end else if (open_ev && state_q == CLOSED) begin
      buf_d = '0;
      cnt_d = 4'd0;
      if (full && buf_q == pw_q) begin
        state_d = OPENED;
        fail_d  = 4'd0;
      end else begin
        fail_d = fail_inc;
        if (fail_inc == 4'(MAX_FAIL)) begin
          state_d = LOCKOUT;
          timer_d = TW'(LOCKOUT_CYC);
        end
      end
    end else if (set_ev && state_q == OPENED && full) begin
      pw_d  = buf_q;
      buf_d = '0;
      cnt_d = 4'd0;
    end else if (key_ev && !full) begin
      buf_d = (buf_q << 4) | W'(digit);
      cnt_d = cnt_q + 4'd1;
    end
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= CLOSED;
      buf_q   <= '0;
      pw_q    <= '0;
      cnt_q   <= 4'd0;
      fail_q  <= 4'd0;
      timer_q <= '0;
      key_q   <= 10'd0;
      open_q  <= 1'b0;
      set_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      pw_q    <= pw_d;
      cnt_q   <= cnt_d;
      fail_q  <= fail_d;
      timer_q <= timer_d;
      key_q   <= key_i;
      open_q  <= open_i;
      set_q   <= set_i;
    end
  end
  assign lock_o      = state_q == OPENED;
  assign alarm_o     = state_q == LOCKOUT;
  assign digit_cnt_o = cnt_q;
  assign fail_cnt_o  = fail_q;
endmodule

// File: tb/tb_dlock_multi.sv
// tb_dlock_multi: directed stimulus, per-cycle comparison against a queue-based lock model.
module tb_dlock_multi;
  localparam int DIGITS = 4, MAX_FAIL = 3, LOCKOUT_CYC = 20;
  logic       clk = 1'b0, rst_n = 1'b0, opn = 1'b0, cls = 1'b0, st = 1'b0;
  logic [9:0] key = 10'd0;
  logic       lock, alarm;
  logic [3:0] dcnt, fcnt;
  int checks = 0, failures = 0;
  dlock_multi #(.DIGITS(DIGITS), .MAX_FAIL(MAX_FAIL), .LOCKOUT_CYC(LOCKOUT_CYC)) dut (
    .clk_i(clk), .rst_ni(rst_n), .key_i(key), .open_i(opn), .close_i(cls), .set_i(st),
    .lock_o(lock), .alarm_o(alarm), .digit_cnt_o(dcnt), .fail_cnt_o(fcnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask
  // Model: mode 0=closed 1=opened 2=lockout; entry/password kept as digit lists.
  int   mode = 0, fails = 0, left = 0, pw[DIGITS], entry[$];
  logic [9:0] pk = 10'd0;
  logic po = 1'b0, ps = 1'b0, seen_rst = 1'b0;
  task automatic model_step();
    bit kev, oev, sev, ok;
    int d;
    if (!rst_n) begin
      mode = 0; fails = 0; left = 0; entry.delete();
      foreach (pw[i]) pw[i] = 0;
      pk = 10'd0; po = 1'b0; ps = 1'b0; seen_rst = 1'b1;
      return;
    end
    kev = $countones(key) == 1 && pk == 10'd0;
    oev = opn && !po;
    sev = st && !ps;
    d = 0;
    for (int i = 0; i < 10; i++) if (key[i]) d = i;
    if (mode == 2) begin
      entry.delete();
      left--;
      if (left == 0) begin mode = 0; fails = 0; end
    end else if (cls) begin
      entry.delete();
      mode = 0;
    end else if (oev && mode == 0) begin
      ok = entry.size() == DIGITS;
      if (ok) foreach (pw[i]) if (entry[i] != pw[i]) ok = 0;
      entry.delete();
      if (ok) begin mode = 1; fails = 0; end
      else begin
        fails = fails < 15 ? fails + 1 : 15;
        if (fails == MAX_FAIL) begin mode = 2; left = LOCKOUT_CYC; end
      end
    end else if (sev && mode == 1 && entry.size() == DIGITS) begin
      foreach (pw[i]) pw[i] = entry[i];
      entry.delete();
    end else if (kev && entry.size() < DIGITS) entry.push_back(d);
    pk = key; po = opn; ps = st;
  endtask
  always @(posedge clk) begin
    model_step();
    #2;
    if (seen_rst) begin
      chk("lock", lock, mode == 1);
      chk("alarm", alarm, mode == 2);
      chk("digit_cnt", dcnt, entry.size());
      chk("fail_cnt", fcnt, fails);
    end
  end
  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask
  task automatic press(input int d);
    key = 10'(1 << d); cyc(); key = 10'd0; cyc();
  endtask
  task automatic pulse(input int which);
    opn = which == 0; st = which == 1; cls = which == 2; cyc();
    opn = 1'b0; st = 1'b0; cls = 1'b0; cyc();
  endtask
  task automatic enter(input int a, input int b, input int c, input int d);
    press(a); press(b); press(c); press(d);
  endtask
  task automatic do_reset();
    rst_n = 1'b0; cyc(); rst_n = 1'b1;
  endtask
  initial begin
    int n;
    cyc(2); rst_n = 1'b1;
    chk("rst_lock", lock, 0); chk("rst_dcnt", dcnt, 0); chk("rst_fail", fcnt, 0);
    enter(0, 0, 0, 0); chk("dcnt_full", dcnt, 4);
    pulse(0); chk("open_default", lock, 1); chk("open_dcnt", dcnt, 0);
    enter(1, 2, 3, 4); pulse(1); chk("set_clear", dcnt, 0);
    pulse(2); chk("close", lock, 0);
    enter(1, 2, 3, 4); pulse(0); chk("open_new_pw", lock, 1);
    pulse(2); enter(1, 2, 3, 5); pulse(0);
    chk("wrong_lock", lock, 0); chk("wrong_fail", fcnt, 1);
    enter(1, 2, 3, 4); pulse(0); chk("fail_cleared", fcnt, 0); pulse(2);
    enter(9, 9, 9, 9); pulse(0); enter(9, 9, 9, 9); pulse(0); enter(9, 9, 9, 9);
    opn = 1'b1; cyc(); opn = 1'b0;
    n = 0;
    while (alarm === 1'b1 && n < 100) begin
      key = (n >= 2 && n < 10 && n % 2 == 0) ? 10'(1 << (n / 2)) : 10'd0;
      opn = n == 10; cls = n == 12;
      n++; cyc();
    end
    key = 10'd0; opn = 1'b0; cls = 1'b0;
    chk("alarm_cycles", n, 20); chk("post_lock_fail", fcnt, 0); chk("post_lock_lock", lock, 0);
    enter(1, 2, 3, 4); pulse(0); chk("post_lock_open", lock, 1); pulse(2);
    press(1); press(2); pulse(0); chk("short_fail", fcnt, 1); chk("short_lock", lock, 0);
    enter(1, 2, 3, 4); press(8); press(9); chk("dcnt_sat", dcnt, 4);
    pulse(0); chk("first4_kept", lock, 1); pulse(2);
    key = 10'h088; cyc(); key = 10'd0; cyc(); chk("multikey", dcnt, 0);
    key = 10'(1 << 5); cyc(3); key = 10'(1 << 6); cyc(2); key = 10'd0; cyc();
    chk("held_key", dcnt, 1); pulse(2);
    enter(1, 2, 3, 4); pulse(0);
    cls = 1'b1; opn = 1'b1; cyc(); cls = 1'b0; opn = 1'b0; cyc();
    chk("close_wins", lock, 0);
    press(1); press(2); press(3);
    key = 10'(1 << 4); opn = 1'b1; cyc(); key = 10'd0; opn = 1'b0; cyc();
    chk("key_vs_open_lock", lock, 0); chk("key_vs_open_fail", fcnt, 1); chk("key_vs_open_dcnt", dcnt, 0);
    press(9); pulse(0); press(9); pulse(0); chk("lockout_again", alarm, 1);
    cyc(3); do_reset();
    chk("rst_mid_alarm", alarm, 0); chk("rst_mid_fail", fcnt, 0); chk("rst_mid_lock", lock, 0);
    press(7); press(7); chk("partial", dcnt, 2);
    do_reset(); chk("rst_entry", dcnt, 0);
    enter(0, 0, 0, 0); pulse(0); chk("pw_reset", lock, 1);
    press(5); press(6); pulse(1); chk("set_short_keep", dcnt, 2); chk("set_short_lock", lock, 1);
    cyc(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
